// File: rtl/apb_arbiter_master.sv
// Two-requester round-robin APB master: one SETUP/ACCESS transfer per grant.
// Optional ACCESS timeout is enabled with APB_TIMEOUT_EN.
module apb_arbiter_master #(
    parameter int ADDR_W         = 8,
    parameter int DATA_W         = 8,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic              PCLK,
    input  logic              PRESETn,
    input  logic              req0_valid,
    input  logic              req0_write,
    input  logic [ADDR_W-1:0] req0_addr,
    input  logic [DATA_W-1:0] req0_wdata,
    output logic              req0_ready,
    output logic              req0_done,
    output logic [DATA_W-1:0] req0_rdata,
    output logic              req0_err,
    input  logic              req1_valid,
    input  logic              req1_write,
    input  logic [ADDR_W-1:0] req1_addr,
    input  logic [DATA_W-1:0] req1_wdata,
    output logic              req1_ready,
    output logic              req1_done,
    output logic [DATA_W-1:0] req1_rdata,
    output logic              req1_err,
    output logic              PSEL,
    output logic              PENABLE,
    output logic              PWRITE,
    output logic [ADDR_W-1:0] PADDR,
    output logic [DATA_W-1:0] PWDATA,
    input  logic [DATA_W-1:0] PRDATA,
    input  logic              PREADY
);
    // state    | meaning
    // S_IDLE   | bus idle, arbitrate and accept one request
    // S_SETUP  | PSEL=1, PENABLE=0 for exactly one cycle
    // S_ACCESS | PSEL=1, PENABLE=1 until PREADY (or timeout)
    typedef enum logic [1:0] {S_IDLE = 2'd0, S_SETUP = 2'd1, S_ACCESS = 2'd2} state_t;

    state_t            r_state;
    logic              r_last_grant;
    logic              r_gnt;
    logic              w_gnt0;
    logic              w_gnt1;
    logic              w_tmo;
    logic              w_end;
    logic [DATA_W-1:0] w_cap;

    // On a tie the port that did not win last time gets the bus.
    assign w_gnt0     = req0_valid & (~req1_valid | r_last_grant);
    assign w_gnt1     = req1_valid & (~req0_valid | ~r_last_grant);
    assign req0_ready = (r_state == S_IDLE) & w_gnt0;
    assign req1_ready = (r_state == S_IDLE) & w_gnt1;

`ifdef APB_TIMEOUT_EN
    localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    logic [TW-1:0] r_tmo_cnt;
    assign w_tmo = (r_state == S_ACCESS) & ~PREADY & (r_tmo_cnt == '0);
`else
    logic w_unused_tmo;
    assign w_unused_tmo = (TIMEOUT_CYCLES > 0);
    assign w_tmo        = 1'b0;
    assign req0_err     = 1'b0;
    assign req1_err     = 1'b0;
`endif

    assign w_end = (r_state == S_ACCESS) & (PREADY | w_tmo);
    assign w_cap = (PREADY & ~PWRITE) ? PRDATA : '0;

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            r_state      <= S_IDLE;
            r_last_grant <= 1'b1;
            r_gnt        <= 1'b0;
            PSEL         <= 1'b0;
            PENABLE      <= 1'b0;
            PWRITE       <= 1'b0;
            PADDR        <= '0;
            PWDATA       <= '0;
            req0_done    <= 1'b0;
            req1_done    <= 1'b0;
            req0_rdata   <= '0;
            req1_rdata   <= '0;
`ifdef APB_TIMEOUT_EN
            r_tmo_cnt    <= '0;
            req0_err     <= 1'b0;
            req1_err     <= 1'b0;
`endif
        end else begin
            req0_done <= 1'b0;
            req1_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_gnt0 | w_gnt1) begin
                        PWRITE       <= w_gnt1 ? req1_write : req0_write;
                        PADDR        <= w_gnt1 ? req1_addr  : req0_addr;
                        PWDATA       <= w_gnt1 ? req1_wdata : req0_wdata;
                        r_gnt        <= w_gnt1;
                        r_last_grant <= w_gnt1;
                        PSEL         <= 1'b1;
                        r_state      <= S_SETUP;
                    end
                end
                S_SETUP: begin
                    PENABLE <= 1'b1;
                    r_state <= S_ACCESS;
`ifdef APB_TIMEOUT_EN
                    r_tmo_cnt <= TW'(TIMEOUT_CYCLES - 1);
`endif
                end
                S_ACCESS: begin
`ifdef APB_TIMEOUT_EN
                    if (!PREADY && r_tmo_cnt != '0)
                        r_tmo_cnt <= r_tmo_cnt - TW'(1);
`endif
                    if (w_end) begin
                        PSEL    <= 1'b0;
                        PENABLE <= 1'b0;
                        r_state <= S_IDLE;
                        if (r_gnt) begin
                            req1_done  <= 1'b1;
                            req1_rdata <= w_cap;
`ifdef APB_TIMEOUT_EN
                            req1_err   <= w_tmo;
`endif
                        end else begin
                            req0_done  <= 1'b1;
                            req0_rdata <= w_cap;
`ifdef APB_TIMEOUT_EN
                            req0_err   <= w_tmo;
`endif
                        end
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end
endmodule
